// File: rtl/iob_pcie_tx_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// iob_pcie_tx_ctrl_pkg
// Shared definitions for the PCIe TX channel controller:
//   - FSM state encoding (3 bits)
//   - words-per-beat constant for the 64-bit channel
//   - beats_from_len(): number of channel beats needed for a word count
// ----------------------------------------------------------------------------
package iob_pcie_tx_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_STREAM = 3'd2,
        ST_DONE   = 3'd3,
        ST_FLUSH  = 3'd4
    } state_t;

    // 32-bit words carried by one 64-bit channel beat
    localparam int BEAT_WORDS = 2;

    // Width of the length register the beat math is sized for
    localparam int LEN_W = 32;

    // Round the word count up to whole beats. Computed one bit wider than
    // the length so that len = all-ones does not wrap (0xFFFFFFFF -> 0x80000000).
    function automatic logic [LEN_W:0] beats_from_len(input logic [LEN_W-1:0] len);
        logic [LEN_W:0] sum;
        sum = {1'b0, len} + (LEN_W+1)'(BEAT_WORDS - 1);
        return sum >> $clog2(BEAT_WORDS);
    endfunction

endpackage

// File: rtl/iob_pcie_skid2.sv
// ----------------------------------------------------------------------------
// iob_pcie_skid2
// Two-entry valid/ready buffer (head + tail) between the TX FIFO read data
// and the channel data pins.
//   clk, rst_n  : clock, async active-low reset
//   flush       : drop all entries (wins over push/pop)
//   push        : push_data lands this cycle
//   push_data   : beat to store
//   pop         : consumer takes the head beat (ignored when head is empty)
//   head_data   : oldest stored beat
//   head_vld    : head_data is valid
//   occ         : number of valid entries (0..2)
// The caller guarantees no push into a full buffer without a same-cycle pop.
// ----------------------------------------------------------------------------
module iob_pcie_skid2 #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         head_vld,
    output logic [1:0]   occ
);

    logic [W-1:0] head_q, tail_q, head_n, tail_n;
    logic         head_v, tail_v, head_vn, tail_vn;

    // Pop first (tail shifts to head), then the landing beat takes the
    // first free slot, so a consume and a landing can share one cycle.
    always_comb begin
        head_n  = head_q;
        tail_n  = tail_q;
        head_vn = head_v;
        tail_vn = tail_v;
        if (flush) begin
            head_vn = 1'b0;
            tail_vn = 1'b0;
        end else begin
            if (pop && head_v) begin
                head_n  = tail_q;
                head_vn = tail_v;
                tail_vn = 1'b0;
            end
            if (push) begin
                if (!head_vn) begin
                    head_n  = push_data;
                    head_vn = 1'b1;
                end else begin
                    tail_n  = push_data;
                    tail_vn = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            head_v <= 1'b0;
            tail_v <= 1'b0;
        end else begin
            head_q <= head_n;
            tail_q <= tail_n;
            head_v <= head_vn;
            tail_v <= tail_vn;
        end
    end

    assign head_data = head_q;
    assign head_vld  = head_v;
    assign occ       = {1'b0, head_v} + {1'b0, tail_v};

endmodule

// File: rtl/iob_pcie_tx_ctrl.sv
// ----------------------------------------------------------------------------
// iob_pcie_tx_ctrl
// Runs one PCIe TX channel transaction at a time for software registers,
// draining a 64-bit TX FIFO into the channel without bubbles.
//   start_i/len_i/off_i/last_i : transaction request (accepted in IDLE only)
//   fifo_empty_i/fifo_rdata_i  : TX FIFO read side (data 1 cycle after ren)
//   fifo_ren_o                 : TX FIFO read enable
//   chnl_tx_*                  : PCIe core channel handshake
//   busy_o                     : transaction in progress
//   done_o                     : one-cycle pulse on normal completion
//   err_o                      : sticky ACK timeout, cleared by next start
// ----------------------------------------------------------------------------
module iob_pcie_tx_ctrl
    import iob_pcie_tx_ctrl_pkg::*;
#(
    parameter int DATA_W           = 32,
    parameter int C_PCI_DATA_WIDTH = 64,
    parameter int TO_W             = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start_i,
    input  logic [DATA_W-1:0]           len_i,
    input  logic [DATA_W-2:0]           off_i,
    input  logic                        last_i,
    input  logic                        fifo_empty_i,
    input  logic [C_PCI_DATA_WIDTH-1:0] fifo_rdata_i,
    output logic                        fifo_ren_o,
    output logic                        chnl_tx_o,
    output logic                        chnl_tx_last_o,
    output logic [DATA_W-1:0]           chnl_tx_len_o,
    output logic [DATA_W-2:0]           chnl_tx_off_o,
    output logic [C_PCI_DATA_WIDTH-1:0] chnl_tx_data_o,
    output logic                        chnl_tx_data_valid_o,
    input  logic                        chnl_tx_data_ren_i,
    input  logic                        chnl_tx_ack_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o
);

    // Last count before the timeout counter would reach all-ones
    localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

    state_t            state;
    logic [DATA_W:0]   beats;
    logic [DATA_W:0]   rd_rem;
    logic [DATA_W:0]   tx_rem;
    logic [TO_W-1:0]   to_cnt;
    logic              inflight;
    logic              tx_q, busy_q, done_q, err_q, last_q;
    logic [DATA_W-1:0] len_q;
    logic [DATA_W-2:0] off_q;

    logic              head_vld;
    logic [1:0]        occ;
    logic [1:0]        occ_eff;
    logic [2:0]        pending;
    logic              consume;
    logic              xfer_state;

    assign beats = beats_from_len(len_i);

    // ------------------------------------------------------------------
    // Output buffer and FIFO read control
    // ------------------------------------------------------------------
    assign chnl_tx_data_valid_o = head_vld && (state == ST_STREAM);
    assign consume              = chnl_tx_data_valid_o && chnl_tx_data_ren_i;
    assign xfer_state           = (state == ST_REQ) || (state == ST_STREAM);

    // A beat consumed this cycle frees its slot, and a read issued last
    // cycle already owns one. Keeping occupancy + in-flight below 2 means
    // a landing beat always has room, while still allowing one read per
    // cycle when the core takes one beat per cycle.
    assign occ_eff    = occ - {1'b0, consume};
    assign pending    = {1'b0, occ_eff} + {2'b0, inflight};
    assign fifo_ren_o = xfer_state && !fifo_empty_i && (rd_rem != '0) && (pending < 3'd2);

    iob_pcie_skid2 #(.W(C_PCI_DATA_WIDTH)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (state == ST_FLUSH),
        .push      (inflight),
        .push_data (fifo_rdata_i),
        .pop       (consume),
        .head_data (chnl_tx_data_o),
        .head_vld  (head_vld),
        .occ       (occ)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
            rd_rem   <= '0;
        end else begin
            inflight <= fifo_ren_o;
            if (state == ST_IDLE && start_i)
                rd_rem <= beats;
            else if (fifo_ren_o)
                rd_rem <= rd_rem - 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Transaction FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            tx_rem <= '0;
            to_cnt <= '0;
            tx_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            last_q <= 1'b0;
            len_q  <= '0;
            off_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        len_q  <= len_i;
                        off_q  <= off_i;
                        last_q <= last_i;
                        tx_rem <= beats;
                        err_q  <= 1'b0;
                        to_cnt <= '0;
                        tx_q   <= 1'b1;
                        busy_q <= 1'b1;
                        state  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // ACK takes priority over a same-cycle timeout
                    if (chnl_tx_ack_i) begin
                        if (tx_rem == '0) begin
                            tx_q   <= 1'b0;
                            done_q <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            state  <= ST_STREAM;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        to_cnt <= to_cnt + 1'b1;
                        err_q  <= 1'b1;
                        tx_q   <= 1'b0;
                        state  <= ST_FLUSH;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (consume) begin
                        tx_rem <= tx_rem - 1'b1;
                        if (tx_rem == (DATA_W+1)'(1)) begin
                            tx_q   <= 1'b0;
                            done_q <= 1'b1;
                            state  <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                ST_FLUSH: begin
                    // Skid buffer is cleared every FLUSH cycle; leave once
                    // no read is still in flight.
                    if (!inflight) begin
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    tx_q   <= 1'b0;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign chnl_tx_o      = tx_q;
    assign chnl_tx_last_o = last_q;
    assign chnl_tx_len_o  = len_q;
    assign chnl_tx_off_o  = off_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_iob_pcie_tx_ctrl.sv
// ----------------------------------------------------------------------------
// tb_iob_pcie_tx_ctrl
// Directed bench for iob_pcie_tx_ctrl with a FIFO model and a beat
// scoreboard: beats expected on the channel are queued as the FIFO is
// loaded and popped as the core consumes them.
// ----------------------------------------------------------------------------
module tb_iob_pcie_tx_ctrl;

    localparam int DATA_W = 32;
    localparam int DW     = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_i = 1'b0;
    logic [DATA_W-1:0] len_i = '0;
    logic [DATA_W-2:0] off_i = '0;
    logic              last_i = 1'b0;
    logic              fifo_empty_i;
    logic [DW-1:0]     fifo_rdata_i = '0;
    logic              fifo_ren_o;
    logic              chnl_tx_o, chnl_tx_last_o;
    logic [DATA_W-1:0] chnl_tx_len_o;
    logic [DATA_W-2:0] chnl_tx_off_o;
    logic [DW-1:0]     chnl_tx_data_o;
    logic              chnl_tx_data_valid_o;
    logic              chnl_tx_data_ren_i = 1'b0;
    logic              chnl_tx_ack_i = 1'b0;
    logic              busy_o, done_o, err_o;

    iob_pcie_tx_ctrl #(.DATA_W(DATA_W), .C_PCI_DATA_WIDTH(DW), .TO_W(4)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .start_i              (start_i),
        .len_i                (len_i),
        .off_i                (off_i),
        .last_i               (last_i),
        .fifo_empty_i         (fifo_empty_i),
        .fifo_rdata_i         (fifo_rdata_i),
        .fifo_ren_o           (fifo_ren_o),
        .chnl_tx_o            (chnl_tx_o),
        .chnl_tx_last_o       (chnl_tx_last_o),
        .chnl_tx_len_o        (chnl_tx_len_o),
        .chnl_tx_off_o        (chnl_tx_off_o),
        .chnl_tx_data_o       (chnl_tx_data_o),
        .chnl_tx_data_valid_o (chnl_tx_data_valid_o),
        .chnl_tx_data_ren_i   (chnl_tx_data_ren_i),
        .chnl_tx_ack_i        (chnl_tx_ack_i),
        .busy_o               (busy_o),
        .done_o               (done_o),
        .err_o                (err_o)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: data held in a queue, read pointer advances on ren
    logic [DW-1:0] fifo_mem[$];
    logic [DW-1:0] exp_q[$];
    int            cons_cyc[$];
    int            rd_ptr = 0;
    int            ren_cnt = 0;
    logic          fifo_clr = 1'b0;
    int            done_cnt = 0;

    assign fifo_empty_i = (rd_ptr >= fifo_mem.size());

    always @(posedge clk) begin
        if (fifo_clr) begin
            rd_ptr <= 0;
        end else if (fifo_ren_o) begin
            fifo_rdata_i <= fifo_mem[rd_ptr];
            rd_ptr       <= rd_ptr + 1;
            ren_cnt      <= ren_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Channel monitor: scoreboard pop on consume, hold-while-stalled check
    logic          prev_vld = 1'b0, prev_ren = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (!rst_n) begin
            prev_vld = 1'b0;
        end else begin
            if (prev_vld && !prev_ren) begin
                chk("hold_valid", 64'(chnl_tx_data_valid_o), 64'd1);
                chk("hold_data", chnl_tx_data_o, prev_data);
            end
            if (chnl_tx_data_valid_o)
                chk("valid_only_in_tx", 64'(chnl_tx_o), 64'd1);
            if (chnl_tx_data_valid_o && chnl_tx_data_ren_i) begin
                cons_cyc.push_back(cyc);
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                chk("beat", chnl_tx_data_o, e);
            end
            if (done_o) done_cnt++;
            prev_vld  = chnl_tx_data_valid_o;
            prev_ren  = chnl_tx_data_ren_i;
            prev_data = chnl_tx_data_o;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] mk(input int t, input int i);
        return 64'hC0DE_0000_0000_0000 | (64'(t) << 16) | 64'(i);
    endfunction

    task automatic load(input int t, input int first, input int n, input int nexp);
        for (int i = 0; i < n; i++) begin
            fifo_mem.push_back(mk(t, first + i));
            if (i < nexp) exp_q.push_back(mk(t, first + i));
        end
    endtask

    task automatic clr_fifo();
        fifo_clr = 1'b1;
        fifo_mem.delete();
        step();
        fifo_clr = 1'b0;
    endtask

    task automatic start_tx(input int len, input int off, input bit last);
        step();
        start_i = 1'b1;
        len_i   = DATA_W'(len);
        off_i   = (DATA_W-1)'(off);
        last_i  = last;
        step();
        start_i = 1'b0;
    endtask

    task automatic ack_after(input int n);
        repeat (n) step();
        chnl_tx_ack_i = 1'b1;
        step();
        chnl_tx_ack_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!done_o && n < budget) begin
            step();
            n++;
        end
        chk(tag, 64'(done_o), 64'd1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy_o && n < budget) begin
            step();
            n++;
        end
        chk(tag, 64'(busy_o), 64'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tx"},    64'(chnl_tx_o), 64'd0);
        chk({tag, "_valid"}, 64'(chnl_tx_data_valid_o), 64'd0);
        chk({tag, "_ren"},   64'(fifo_ren_o), 64'd0);
        chk({tag, "_busy"},  64'(busy_o), 64'd0);
        chk({tag, "_done"},  64'(done_o), 64'd0);
        chk({tag, "_err"},   64'(err_o), 64'd0);
        chk({tag, "_len"},   64'(chnl_tx_len_o), 64'd0);
        chk({tag, "_off"},   64'(chnl_tx_off_o), 64'd0);
        chk({tag, "_last"},  64'(chnl_tx_last_o), 64'd0);
        chk({tag, "_data"},  chnl_tx_data_o, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_ren, base_done, base_cons, n;
        logic [1:0] pat [4];
        pat[0] = 2'd1; pat[1] = 2'd0; pat[2] = 2'd0; pat[3] = 2'd1;

        // Reset state
        repeat (3) step();
        chk_all_zero("reset");
        rst_n = 1'b1;
        step();

        // T1: len=8, 4 beats preloaded, continuous ren
        load(1, 0, 4, 4);
        chnl_tx_data_ren_i = 1'b1;
        base_ren = ren_cnt; base_done = done_cnt; base_cons = cons_cyc.size();
        start_tx(8, 0, 1'b1);
        chk("t1_tx", 64'(chnl_tx_o), 64'd1);
        chk("t1_busy", 64'(busy_o), 64'd1);
        chk("t1_len", 64'(chnl_tx_len_o), 64'd8);
        chk("t1_last", 64'(chnl_tx_last_o), 64'd1);
        chk("t1_valid_before_ack", 64'(chnl_tx_data_valid_o), 64'd0);
        ack_after(2);
        wait_done("t1_done", 40);
        chk("t1_tx_low_at_done", 64'(chnl_tx_o), 64'd0);
        chk("t1_done_after_last", 64'(cyc), 64'(cons_cyc[cons_cyc.size()-1] + 1));
        chk("t1_no_bubble", 64'(cons_cyc[base_cons+3] - cons_cyc[base_cons]), 64'd3);
        step();
        chk("t1_busy_low", 64'(busy_o), 64'd0);
        chk("t1_ren_count", 64'(ren_cnt - base_ren), 64'd4);
        chk("t1_beats_sent", 64'(cons_cyc.size() - base_cons), 64'd4);
        chk("t1_done_pulses", 64'(done_cnt - base_done), 64'd1);
        clr_fifo();

        // T2: len=5 (odd) -> 3 beats even with 6 in the FIFO
        load(2, 0, 6, 3);
        base_ren = ren_cnt; base_cons = cons_cyc.size();
        start_tx(5, 3, 1'b0);
        chk("t2_len", 64'(chnl_tx_len_o), 64'd5);
        chk("t2_off", 64'(chnl_tx_off_o), 64'd3);
        chk("t2_last", 64'(chnl_tx_last_o), 64'd0);
        ack_after(1);
        wait_idle("t2_idle", 40);
        repeat (3) step();
        chk("t2_ren_count", 64'(ren_cnt - base_ren), 64'd3);
        chk("t2_beats_sent", 64'(cons_cyc.size() - base_cons), 64'd3);
        chk("t2_scoreboard_empty", 64'(exp_q.size()), 64'd0);
        clr_fifo();

        // T3: len=0, start while busy is ignored
        load(3, 0, 1, 0);
        base_ren = ren_cnt; base_done = done_cnt; base_cons = cons_cyc.size();
        start_tx(0, 0, 1'b1);
        chk("t3_tx", 64'(chnl_tx_o), 64'd1);
        start_i = 1'b1; len_i = 32'd7;
        step();
        start_i = 1'b0;
        chk("t3_len_unchanged", 64'(chnl_tx_len_o), 64'd0);
        ack_after(1);
        wait_done("t3_done", 10);
        step();
        chk("t3_busy_low", 64'(busy_o), 64'd0);
        chk("t3_ren_count", 64'(ren_cnt - base_ren), 64'd0);
        chk("t3_no_beats", 64'(cons_cyc.size() - base_cons), 64'd0);
        chk("t3_done_pulses", 64'(done_cnt - base_done), 64'd1);
        clr_fifo();

        // T4: len=16, ren 1,0,0,1 and FIFO running dry mid-stream
        load(4, 0, 3, 3);
        for (int i = 3; i < 8; i++) exp_q.push_back(mk(4, i));
        base_ren = ren_cnt; base_done = done_cnt; base_cons = cons_cyc.size();
        chnl_tx_data_ren_i = 1'b0;
        start_tx(16, 0, 1'b1);
        ack_after(1);
        n = 0;
        while (busy_o && n < 300) begin
            chnl_tx_data_ren_i = pat[n % 4][0];
            if (n == 20) load(4, 3, 5, 0);
            step();
            n++;
        end
        chk("t4_idle", 64'(busy_o), 64'd0);
        chk("t4_ren_count", 64'(ren_cnt - base_ren), 64'd8);
        chk("t4_beats_sent", 64'(cons_cyc.size() - base_cons), 64'd8);
        chk("t4_scoreboard_empty", 64'(exp_q.size()), 64'd0);
        chk("t4_done_pulses", 64'(done_cnt - base_done), 64'd1);
        clr_fifo();

        // T5: no ACK -> timeout after 15 REQ cycles (TO_W=4), prefetch discarded
        load(5, 0, 2, 0);
        base_done = done_cnt;
        chnl_tx_data_ren_i = 1'b1;
        start_tx(4, 0, 1'b0);
        n = 0;
        while (!err_o && n < 40) begin
            step();
            n++;
        end
        chk("t5_err", 64'(err_o), 64'd1);
        chk("t5_req_cycles", 64'(n), 64'd15);
        chk("t5_tx_low", 64'(chnl_tx_o), 64'd0);
        wait_idle("t5_idle", 10);
        step();
        chk("t5_no_done", 64'(done_cnt - base_done), 64'd0);
        chk("t5_err_sticky", 64'(err_o), 64'd1);
        clr_fifo();
        load(5, 10, 1, 1);
        start_tx(2, 0, 1'b0);
        chk("t5_err_cleared", 64'(err_o), 64'd0);
        ack_after(1);
        wait_done("t5_recover_done", 20);
        step();
        clr_fifo();

        // T6: reset during beat 2 of 4, then a normal len=2 transaction
        load(6, 0, 4, 4);
        base_cons = cons_cyc.size();
        start_tx(8, 0, 1'b1);
        ack_after(1);
        n = 0;
        while (cons_cyc.size() < base_cons + 2 && n < 20) begin
            step();
            n++;
        end
        chk("t6_two_beats", 64'(cons_cyc.size() - base_cons), 64'd2);
        rst_n = 1'b0;
        #1;
        chk_all_zero("t6_async_reset");
        exp_q.delete();
        clr_fifo();
        step();
        rst_n = 1'b1;
        step();
        load(6, 10, 1, 1);
        base_done = done_cnt; base_cons = cons_cyc.size();
        start_tx(2, 0, 1'b1);
        ack_after(1);
        wait_done("t6_done", 20);
        step();
        chk("t6_beats_sent", 64'(cons_cyc.size() - base_cons), 64'd1);
        chk("t6_done_pulses", 64'(done_cnt - base_done), 64'd1);
        chk("t6_busy_low", 64'(busy_o), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
